// File: rtl/lsu_mem_ctrl.sv
// Load/store request controller in front of the SRAM model: one access in flight,
// single-cycle memory strobe, load extraction/extension and error reporting.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [4:0]  req_rd,
  output logic        ld_wen,
  output logic        st_wen,
  output logic [31:0] raddr,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic [7:0]  wmask,
  input  logic [31:0] rdata,
  input  logic        rdata_ok,
  input  logic        wdata_ok,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic [1:0]  resp_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_load_q, is_load_d;
  logic               is_store_q, is_store_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [4:0]         rd_q, rd_d;
  logic [31:0]        resp_data_q, resp_data_d;
  logic [1:0]         resp_err_q, resp_err_d;
  logic               ready_q, ready_d;

  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic [4:0]  lane_shamt;
  logic [31:0] ld_shifted;
  logic [31:0] ld_ext;
  logic [3:0]  st_mask;
  logic        in_req;

  assign accept     = req_valid & ready_q;
  assign illegal    = (req_is_load == req_is_store) | (req_size == 2'd3);
  assign misaligned = ((req_size == 2'd1) & req_addr[0]) |
                      ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));

  assign lane_shamt = {addr_q[1:0], 3'b000};
  assign ld_shifted = rdata >> lane_shamt;

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    ld_ext = ld_shifted;
    case (size_q)
      2'd0:    ld_ext = {{24{~uns_q & ld_shifted[7]}}, ld_shifted[7:0]};
      2'd1:    ld_ext = {{16{~uns_q & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_ext = ld_shifted;
    endcase
  end

  always_comb begin
    st_mask = 4'b1111;
    case (size_q)
      2'd0:    st_mask = 4'b0001 << addr_q[1:0];
      2'd1:    st_mask = 4'b0011 << addr_q[1:0];
      default: st_mask = 4'b1111;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_load_d   = is_load_q;
    is_store_d  = is_store_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rd_d        = rd_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_load_d  = req_is_load;
          is_store_d = req_is_store;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          size_d     = req_size;
          uns_d      = req_unsigned;
          rd_d       = req_rd;
          // Bad requests skip the memory entirely and answer on the next cycle.
          if (illegal) begin
            state_d     = S_RESP;
            resp_err_d  = ERR_ILLEGAL;
            resp_data_d = '0;
          end else if (misaligned) begin
            state_d     = S_RESP;
            resp_err_d  = ERR_MISALIGN;
            resp_data_d = '0;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // Only the ok matching the access type completes it.
        if (is_load_q & rdata_ok) begin
          state_d     = S_RESP;
          resp_data_d = ld_ext;
          resp_err_d  = ERR_OK;
        end else if (is_store_q & wdata_ok) begin
          state_d     = S_RESP;
          resp_data_d = '0;
          resp_err_d  = ERR_OK;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d     = S_RESP;
          resp_data_d = '0;
          resp_err_d  = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Registered so req_ready never depends combinationally on reset or req_valid.
    ready_d = (state_d == S_IDLE);
  end

  // NOTE: reset is synchronous active-low and clears every register, datapath included.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_load_q   <= 1'b0;
      is_store_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      rd_q        <= '0;
      resp_data_q <= '0;
      resp_err_q  <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_load_q   <= is_load_d;
      is_store_q  <= is_store_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rd_q        <= rd_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      ready_q     <= ready_d;
    end
  end

  assign in_req = (state_q == S_REQ);

  assign req_ready  = ready_q;
  assign ld_wen     = in_req & is_load_q;
  assign st_wen     = in_req & is_store_q;
  assign raddr      = ld_wen ? {addr_q[31:2], 2'b00} : '0;
  assign waddr      = st_wen ? {addr_q[31:2], 2'b00} : '0;
  assign wdata      = st_wen ? (wdata_q << lane_shamt) : '0;
  assign wmask      = st_wen ? {4'b0000, st_mask} : '0;
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = resp_data_q;
  assign resp_rd    = rd_q;
  assign resp_err   = resp_err_q;

endmodule
